// File: rtl/flash_cmd_seq_if.sv
// Host-request and instruction-queue signals of the flash command sequencer.
// The sequencer takes the slave side; the host/FIFO environment takes the master side.
interface flash_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_row;
  logic [15:0] req_col;
  logic        iq_full;
  logic        iq_wreq;
  logic [31:0] iq_wdata;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_op, req_row, req_col, iq_full,
    input  req_ready, iq_wreq, iq_wdata, busy, done
  );

  modport slave (
    input  req_valid, req_op, req_row, req_col, iq_full,
    output req_ready, iq_wreq, iq_wdata, busy, done
  );
endinterface

// File: rtl/flash_cmd_seq.sv
// Expands one page-level host request into the ordered flash_ctrl mode instructions
// and pushes them into the instruction queue, one word per non-stalled cycle.
//   state | meaning
//   IDLE  | ready for a request, queue write inactive
//   EMIT  | presenting instruction 'step' of the latched request, writing when queue not full
module flash_cmd_seq #(
  parameter int PAGE_BYTES = 4320
) (
  input logic           clk,
  input logic           rst,
  flash_cmd_seq_if.slave bus
);

  localparam logic [2:0]  MODE_STBY = 3'd0;
  localparam logic [2:0]  MODE_CMD  = 3'd2;
  localparam logic [2:0]  MODE_ADDR = 3'd3;
  localparam logic [2:0]  MODE_DIN  = 3'd4;
  localparam logic [2:0]  MODE_DOUT = 3'd5;
  localparam logic [2:0]  MODE_WRB  = 3'd7;
  localparam logic [12:0] DATA_REP  = 13'(PAGE_BYTES - 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [1:0]  op_q, op_d;
  logic [23:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic        done_q, done_d;

  logic [2:0]  mode;
  logic [12:0] rep;
  logic [7:0]  byte_v;
  logic [3:0]  last_step;
  logic        accept;
  logic        wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    last_step = 4'd8;
    case (op_q)
      OP_ERASE: last_step = 4'd5;
      OP_RESET: last_step = 4'd1;
      default:  last_step = 4'd8;
    endcase
  end

  // Read and program share the five-cycle column/row address phase at steps 1..5.
  always_comb begin
    mode   = MODE_STBY;
    rep    = '0;
    byte_v = '0;
    case (op_q)
      OP_READ, OP_PROG: begin
        case (step_q)
          4'd0: begin mode = MODE_CMD;  byte_v = (op_q == OP_READ) ? 8'h00 : 8'h80; end
          4'd1: begin mode = MODE_ADDR; byte_v = col_q[7:0];   end
          4'd2: begin mode = MODE_ADDR; byte_v = col_q[15:8];  end
          4'd3: begin mode = MODE_ADDR; byte_v = row_q[7:0];   end
          4'd4: begin mode = MODE_ADDR; byte_v = row_q[15:8];  end
          4'd5: begin mode = MODE_ADDR; byte_v = row_q[23:16]; end
          4'd6: begin
            if (op_q == OP_READ) begin
              mode   = MODE_CMD;
              byte_v = 8'h30;
            end else begin
              mode = MODE_DIN;
              rep  = DATA_REP;
            end
          end
          4'd7: begin
            if (op_q == OP_READ) begin
              mode = MODE_WRB;
            end else begin
              mode   = MODE_CMD;
              byte_v = 8'h10;
            end
          end
          default: begin
            if (op_q == OP_READ) begin
              mode = MODE_DOUT;
              rep  = DATA_REP;
            end else begin
              mode = MODE_WRB;
            end
          end
        endcase
      end
      OP_ERASE: begin
        case (step_q)
          4'd0:    begin mode = MODE_CMD;  byte_v = 8'h60;        end
          4'd1:    begin mode = MODE_ADDR; byte_v = row_q[7:0];   end
          4'd2:    begin mode = MODE_ADDR; byte_v = row_q[15:8];  end
          4'd3:    begin mode = MODE_ADDR; byte_v = row_q[23:16]; end
          4'd4:    begin mode = MODE_CMD;  byte_v = 8'hD0;        end
          default: begin mode = MODE_WRB;                         end
        endcase
      end
      default: begin
        if (step_q == 4'd0) begin
          mode   = MODE_CMD;
          byte_v = 8'hFF;
        end else begin
          mode = MODE_WRB;
        end
      end
    endcase
  end

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign wr_en  = (state_q == EMIT) && !bus.iq_full;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.req_op;
          row_d   = bus.req_row;
          col_d   = bus.req_col;
          step_d  = '0;
          state_d = EMIT;
        end
      end
      default: begin
        if (wr_en) begin
          if (step_q == last_step) begin
            step_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == EMIT);
  assign bus.done      = done_q;
  assign bus.iq_wreq   = wr_en;
  assign bus.iq_wdata  = (state_q == EMIT) ? {mode, rep, 8'h00, byte_v} : 32'h0;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Scoreboard bench for flash_cmd_seq: stimulus pushes expected instruction words,
// a negedge monitor pops and compares each queue write and the done pulse.
module tb_flash_cmd_seq;

  typedef struct {
    logic [31:0] w;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  flash_cmd_seq_if bus ();

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  bit   done_exp = 1'b0;

  flash_cmd_seq #(.PAGE_BYTES(4320)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      chk("done", {31'b0, bus.done}, {31'b0, done_exp});
      done_exp = 1'b0;
      if (bus.iq_wreq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", bus.iq_wdata, 32'hFFFF_FFFF ^ bus.iq_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("iq_wdata", bus.iq_wdata, e.w);
          done_exp = e.last;
          wr_cnt++;
        end
      end
    end
  end

  task automatic push(input logic [31:0] w, input bit last);
    exp_t e;
    e.w = w;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [1:0] op, input logic [23:0] row, input logic [15:0] col);
    case (op)
      2'd0, 2'd1: begin
        push((op == 2'd0) ? 32'h4000_0000 : 32'h4000_0080, 1'b0);
        push(32'h6000_0000 | col[7:0], 1'b0);
        push(32'h6000_0000 | col[15:8], 1'b0);
        push(32'h6000_0000 | row[7:0], 1'b0);
        push(32'h6000_0000 | row[15:8], 1'b0);
        push(32'h6000_0000 | row[23:16], 1'b0);
        if (op == 2'd0) begin
          push(32'h4000_0030, 1'b0);
          push(32'hE000_0000, 1'b0);
          push(32'hB0DF_0000, 1'b1);   // mode 5, repeat 4319
        end else begin
          push(32'h90DF_0000, 1'b0);   // mode 4, repeat 4319
          push(32'h4000_0010, 1'b0);
          push(32'hE000_0000, 1'b1);
        end
      end
      2'd2: begin
        push(32'h4000_0060, 1'b0);
        push(32'h6000_0000 | row[7:0], 1'b0);
        push(32'h6000_0000 | row[15:8], 1'b0);
        push(32'h6000_0000 | row[23:16], 1'b0);
        push(32'h4000_00D0, 1'b0);
        push(32'hE000_0000, 1'b1);
      end
      default: begin
        push(32'h4000_00FF, 1'b0);
        push(32'hE000_0000, 1'b1);
      end
    endcase
  endtask

  // Called at posedge+1; returns at acceptance posedge+1 with req_valid dropped unless held.
  task automatic issue(input logic [1:0] op, input logic [23:0] row, input logic [15:0] col,
                       input bit hold);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_row   = row;
    bus.req_col   = col;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    if (n == 200) chk("accept_timeout", 32'd0, 32'd1);
    push_seq(op, row, col);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    if (n == 100) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.iq_full   = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_iq_wreq",   {31'b0, bus.iq_wreq},   32'd0);
    chk("rst_busy",      {31'b0, bus.busy},      32'd0);
    chk("rst_done",      {31'b0, bus.done},      32'd0);
    chk("rst_iq_wdata",  bus.iq_wdata,           32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // plain read, queue never full
    issue(2'd0, 24'h123456, 16'h0ABC, 1'b0);
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    chk("first_wreq", {31'b0, bus.iq_wreq}, 32'd1);
    chk("first_word", bus.iq_wdata, 32'h4000_0000);
    wait_done();

    // program with queue full in EMIT cycles 3..6
    issue(2'd1, 24'h123456, 16'h0ABC, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.iq_full = 1'b1;
    @(negedge clk);
    chk("stall_wreq", {31'b0, bus.iq_wreq}, 32'd0);
    chk("stall_busy", {31'b0, bus.busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    bus.iq_full = 1'b0;
    wait_done();

    // read with queue full toggling every cycle
    issue(2'd0, 24'h89ABCD, 16'h1357, 1'b0);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
      bus.iq_full = ~bus.iq_full;
      n++;
    end
    if (n == 60) chk("toggle_timeout", 32'd0, 32'd1);
    bus.iq_full = 1'b0;
    @(posedge clk);
    #1;

    // erase, then reset accepted in the done cycle
    issue(2'd2, 24'h00FFEE, 16'h0000, 1'b0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    if (n == 100) chk("erase_done_timeout", 32'd0, 32'd1);
    chk("done_cycle_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd3;
    push_seq(2'd3, 24'h0, 16'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("back_to_back_busy", {31'b0, bus.busy}, 32'd1);
    chk("back_to_back_ready", {31'b0, bus.req_ready}, 32'd0);
    wait_done();

    // held req_valid with changing inputs while busy
    issue(2'd2, 24'h0A0B0C, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.req_row = 24'h5A5A00 + 24'(i);
      bus.req_op  = 2'(i);
      @(negedge clk);
      chk("held_ready", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    wait_done();

    // async reset after the third write of a read
    base = wr_cnt;
    issue(2'd0, 24'h123456, 16'h0ABC, 1'b0);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      if (wr_cnt - base >= 3) break;
      n++;
    end
    if (n == 50) chk("third_write_timeout", 32'd0, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wreq",  {31'b0, bus.iq_wreq},   32'd0);
    chk("mid_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("mid_rst_busy",  {31'b0, bus.busy},      32'd0);
    chk("mid_rst_done",  {31'b0, bus.done},      32'd0);
    chk("mid_rst_writes", 32'(wr_cnt - base), 32'd3);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = wr_cnt;
    issue(2'd3, 24'h0, 16'h0, 1'b0);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_writes", 32'(wr_cnt - base), 32'd2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
